// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: synchronizes SCL/SDA, decodes START/STOP, ACKs its address and each data byte.
// Optional macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchronizer.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_match
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       addr_match_q, addr_match_d;

    // Synchronizers reset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_s = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                   (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_s = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                   (sda_hist_q[1] & sda_hist_q[2]);
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;
        if (stop_det) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            bit_cnt_d    = 4'd0;
        end else if (start_det) begin
            state_d      = ADDR;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            bit_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    // Counter saturates at 8; the byte completes on the following SCL fall.
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == DATA) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = DATA_ACK;
                        end else if (shift_q[7:1] == TARGET_ADDR && !shift_q[0]) begin
                            sda_oe_d     = 1'b1;
                            addr_match_d = 1'b1;
                            state_d      = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = DATA;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                IDLE:    state_d  = IDLE;
                default: state_d  = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: bit-banged I2C master, transaction-level model and per-cycle compare process.
// Expectations for the glitch scenario follow I2C_TGT_GLITCH_FILTER_EN.
module tb_i2c_target_rx;

    localparam logic [6:0] TGT = 7'h42;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       addr_match;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    bit         oe_allowed = 1'b0;
    bit         oe_hold = 1'b0;
    bit         model_matched = 1'b0;
    bit         rx_valid_prev = 1'b0;

    // Open-drain bus: either side may pull SDA low.
    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.TARGET_ADDR(TGT)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_drv),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .addr_match (addr_match)
    );

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every received byte must match the oldest model prediction; SDA may only be pulled where an ACK is due.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL rx_valid_unexpected: got rx_data %0h expected no pulse", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        mismatched++;
                        $display("[TB] FAIL rx_data: got %0h expected %0h", rx_data, e);
                    end
                end
                if (rx_valid_prev) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL rx_valid_width: got 2+ cycles expected 1");
                end
            end
            if (sda_oe && !oe_allowed) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sda_oe_spurious: got 1 expected 0 at %0t", $time);
            end
            rx_valid_prev = rx_valid;
        end else begin
            rx_valid_prev = 1'b0;
        end
    end

    task automatic driveBit(input logic b, input bit glitch);
        scl_drv = 1'b0;
        waitClk(5);
        if ($urandom_range(0, 3) == 0) sda_drv = ~sda_drv;
        waitClk(1);
        sda_drv = b;
        waitClk(2);
        if (!oe_hold) oe_allowed = 1'b0;
        if (glitch) begin
            scl_drv = 1'b1;
            waitClk(1);
            scl_drv = 1'b0;
            waitClk(3);
        end else begin
            waitClk(4);
        end
        scl_drv = 1'b1;
        waitClk(12);
    endtask

    task automatic ackSlot(input bit ack_exp, input bit is_addr, input bit check);
        scl_drv = 1'b0;
        if (ack_exp) oe_allowed = 1'b1;
        waitClk(6);
        sda_drv = 1'b1;
        waitClk(6);
        scl_drv = 1'b1;
        waitClk(6);
        if (check) begin
            checkOutput(is_addr ? "addr_ack" : "data_ack", sda_oe, ack_exp);
            checkOutput("addr_match_in_slot", addr_match, model_matched);
        end
        waitClk(6);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit is_addr, input int glitch_bit);
        bit ack_exp;
        for (int i = 7; i >= 0; i--) driveBit(b[i], (7 - i) == glitch_bit);
        if (is_addr) begin
            ack_exp = (b[7:1] == TGT) && !b[0];
            model_matched = ack_exp;
        end else begin
            ack_exp = model_matched;
            if (ack_exp) exp_q.push_back(b);
        end
        ackSlot(ack_exp, is_addr, 1'b1);
    endtask

    task automatic doStart();
        sda_drv = 1'b0;
        waitClk(12);
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic doRestart();
        scl_drv = 1'b0;
        waitClk(6);
        sda_drv = 1'b1;
        waitClk(6);
        oe_allowed = 1'b0;
        scl_drv = 1'b1;
        waitClk(12);
        sda_drv = 1'b0;
        model_matched = 1'b0;
        waitClk(12);
        checkOutput("addr_match_after_restart", addr_match, 0);
        checkOutput("busy_after_restart", busy, 1);
    endtask

    task automatic doStop();
        scl_drv = 1'b0;
        waitClk(6);
        sda_drv = 1'b0;
        waitClk(6);
        oe_allowed = 1'b0;
        scl_drv = 1'b1;
        waitClk(12);
        sda_drv = 1'b1;
        model_matched = 1'b0;
        waitClk(12);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("addr_match_after_stop", addr_match, 0);
        checkOutput("sda_oe_after_stop", sda_oe, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sda_oe"}, sda_oe, 0);
        checkOutput({tag, "_rx_valid"}, rx_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_addr_match"}, addr_match, 0);
        checkOutput({tag, "_rx_data"}, rx_data, 8'h00);
    endtask

    task automatic applyStimulus();
        logic [7:0] v;
        logic [7:0] ab;
        bit         in_txn;
        int         n;

        // Basic write: address 0x42/W then 0xA5.
        doStart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
        sendByte(8'hA5, 1'b0, -1);
        doStop();
        checkOutput("rx_data_A5", rx_data, 8'hA5);

        // Foreign address: nothing may be ACKed or reported.
        doStart();
        sendByte({7'h43, 1'b0}, 1'b1, -1);
        sendByte(8'h11, 1'b0, -1);
        doStop();

        // Read request is NACKed.
        doStart();
        sendByte({TGT, 1'b1}, 1'b1, -1);
        sendByte(8'h77, 1'b0, -1);
        doStop();

        // Repeated START between two writes.
        doStart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
        sendByte(8'h3C, 1'b0, -1);
        doRestart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
        sendByte(8'hC3, 1'b0, -1);
        doStop();
        checkOutput("rx_data_C3", rx_data, 8'hC3);

        // Reset pulse after the 4th data bit of 0x5A, then a full resend.
        v = 8'h5A;
        doStart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
        for (int i = 7; i >= 4; i--) driveBit(v[i], 1'b0);
        waitClk(2);
        rst = 1'b0;
        waitClk(2);
        checkResetValues("mid_reset");
        waitClk(2);
        rst = 1'b1;
        model_matched = 1'b0;
        for (int i = 3; i >= 0; i--) driveBit(v[i], 1'b0);
        ackSlot(1'b0, 1'b0, 1'b1);
        doStop();
        doStart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
        sendByte(8'h5A, 1'b0, -1);
        doStop();
        checkOutput("rx_data_5A", rx_data, 8'h5A);

        // SCL glitch during the low phase of the 4th bit of 0x96.
        doStart();
        sendByte({TGT, 1'b0}, 1'b1, -1);
`ifdef I2C_TGT_GLITCH_FILTER_EN
        sendByte(8'h96, 1'b0, 3);
        doStop();
        checkOutput("glitch_filtered", rx_data, 8'h96);
`else
        // Bit 3 is sampled twice: 1,0,0,1,1,0,1,1 -> 0x9B, acknowledged one bit early.
        v = 8'h96;
        exp_q.push_back(8'h9B);
        oe_hold = 1'b1;
        oe_allowed = 1'b1;
        for (int i = 7; i >= 0; i--) driveBit(v[i], (7 - i) == 3);
        ackSlot(1'b0, 1'b0, 1'b0);
        oe_hold = 1'b0;
        doStop();
        checkOutput("glitch_corrupts", rx_data, 8'h9B);
`endif

        // Random transactions against the model.
        in_txn = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (!in_txn) doStart();
            case ($urandom_range(0, 3))
                0, 1:    ab = {TGT, 1'b0};
                2:       ab = {7'h43, 1'b0};
                default: ab = 8'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) ab[0] = 1'b1;
            sendByte(ab, 1'b1, -1);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                v = 8'($urandom);
                sendByte(v, 1'b0, -1);
            end
            if ($urandom_range(0, 3) == 0 && t != 29) begin
                doRestart();
                in_txn = 1'b1;
            end else begin
                doStop();
                in_txn = 1'b0;
                waitClk($urandom_range(5, 30));
            end
        end
        waitClk(10);
        checkOutput("pending_expected_bytes", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        waitClk(5);
        checkResetValues("por");
        rst = 1'b1;
        waitClk(10);
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h42, 7-bit address this target answers to.
REQ-002 clk  input  1  system clock; samples the bus at ≥10x the SCL rate.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 scl_in  input  1  raw SCL from the bus; asynchronous to clk.
REQ-005 sda_in  input  1  raw SDA from the bus; asynchronous to clk.
REQ-006 sda_oe  output  1  1 pulls SDA low (open-drain ACK driver); 0 releases SDA.
REQ-007 rx_data  output  8  last received data byte, MSB first on the bus.
REQ-008 rx_valid  output  1  one-clk pulse; rx_data is new on this cycle.
REQ-009 busy  output  1  high from START until STOP.
REQ-010 addr_match  output  1  high from the address ACK slot until STOP or repeated START.

Function
REQ-011 scl_in and sda_in SHALL each pass through a 2-FF synchronizer; all logic SHALL use the synchronized values only.
REQ-012 START = synced SDA falls while synced SCL is high; STOP = synced SDA rises while synced SCL is high.
REQ-013 Data bits SHALL be sampled on the clk cycle the synced SCL rising edge is detected.
REQ-014 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE -> ADDR on START; the bit counter clears to 0.
REQ-016 ADDR: shift in 8 bits (7 address bits, then R/W). After the 8th bit, on the next SCL falling edge:
  - address equal and R/W=0 -> ADDR_ACK with sda_oe=1;
  - otherwise -> IGNORE with sda_oe=0.
REQ-017 ADDR_ACK: release sda_oe on the next SCL falling edge, then -> DATA.
REQ-018 DATA: shift in 8 bits; after the 8th bit, on the next SCL falling edge:
  - rx_data updates;
  - rx_valid pulses for exactly 1 clk;
  - sda_oe=1;
  - -> DATA_ACK.
REQ-019 DATA_ACK: release sda_oe on the next SCL falling edge, bit counter = 0, -> DATA.
REQ-020 IGNORE: sda_oe held 0; wait for STOP or START.
REQ-021 STOP in any state -> IDLE, sda_oe=0, busy=0, addr_match=0; a partial byte is discarded with no rx_valid.
REQ-022 Repeated START in any non-IDLE state -> ADDR; addr_match clears and the bit counter clears.
REQ-023 Read requests (R/W=1) are unsupported: the address is NACKed and the state goes to IGNORE.
REQ-024 The bit counter is 4 bits and SHALL never exceed 8; no wrap-around.
REQ-025 A START and STOP cannot coincide; an SDA edge with SCL high is classified by edge direction only.
REQ-026 SDA edges while SCL is low SHALL NOT affect the state machine.

Reset
REQ-027 rst low SHALL immediately force:
  - state IDLE;
  - sda_oe=0, rx_valid=0, busy=0, addr_match=0;
  - rx_data=8'h00;
  - bit counter 0;
  - synchronizer flops to 1 (idle bus).
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer. After release, the block waits for a fresh START; it SHALL NOT ACK a byte that is already in progress.

Configuration
REQ-029 Macro I2C_TGT_GLITCH_FILTER_EN.
  - Defined: each synchronized line additionally passes a 3-sample majority filter. This adds 2 clk latency, and single-clk glitches on SCL or SDA SHALL be rejected.
  - Undefined: no filter; the 2-FF synchronizer latency only; every synced transition is acted on.

Verification
REQ-030 Address 0x42 with W, then data 0xA5, then STOP:
  - ACK driven in both ACK slots;
  - rx_valid pulses once with rx_data=8'hA5;
  - busy and addr_match fall after STOP.
REQ-031 Address 0x43 with W, then 0x11: sda_oe never asserted, rx_valid never pulses, state stays IGNORE until STOP.
REQ-032 Address 0x42 with R: NACK in the address ACK slot; no rx_valid.
REQ-033 Address 0x42 with W, 0x3C, then repeated START, 0x42 with W, 0xC3, then STOP: rx_valid pulses twice, with 8'h3C then 8'hC3.
REQ-034 rst pulsed low after the 4th data bit of 0x5A, then the full transfer resent: outputs are at reset values during the pulse; only the resent byte is reported.
REQ-035 With I2C_TGT_GLITCH_FILTER_EN defined, inject a 1-clk SCL high glitch mid-bit: no extra bit is shifted and the byte value is unchanged. Without the macro, the same stimulus corrupts the byte.
